// File: rtl/otter_pkg.sv
// rtl/otter_pkg.sv - shared types for the OTTER hazard and forwarding controller
package otter_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2,
    FWD_BYP = 2'd3
  } fwd_sel_t;

  typedef enum logic {
    IDLE    = 1'b0,
    LDSTALL = 1'b1
  } hz_state_t;

endpackage

// File: rtl/otter_fwd_sel.sv
// rtl/otter_fwd_sel.sv - per-operand source match and forwarding priority
module otter_fwd_sel
  import otter_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic              rs_used_i,
  input  logic [ADDR_W-1:0] rd_e_i,
  input  logic [ADDR_W-1:0] rd_m_i,
  input  logic [ADDR_W-1:0] rd_w_i,
  input  logic              regwrite_e_i,
  input  logic              regwrite_m_i,
  input  logic              regwrite_w_i,
  input  logic              memread_e_i,
  output logic [1:0]        sel_o,
  output logic              load_use_o
);

  logic src_live;
  logic match_e;
  logic match_m;
  logic match_w;

  // x0 never carries a dependency, so it is excluded once here for every stage
  assign src_live   = rs_used_i && (rs_addr_i != '0);
  assign match_e    = src_live && regwrite_e_i && (rd_e_i == rs_addr_i);
  assign match_m    = src_live && regwrite_m_i && (rd_m_i == rs_addr_i);
  assign match_w    = src_live && regwrite_w_i && (rd_w_i == rs_addr_i);
  assign load_use_o = match_e && memread_e_i;

  always_comb begin
    sel_o = FWD_RF;
    if (match_e && !memread_e_i) begin
      sel_o = FWD_MEM;
    end else if (match_m) begin
      sel_o = FWD_WB;
    end else if (match_w) begin
      sel_o = FWD_BYP;
    end
  end

endmodule

// File: rtl/otter_hazard_unit.sv
// rtl/otter_hazard_unit.sv - load-use stall, redirect flush and forwarding control
// Optional performance counters are built when OTTER_HAZARD_PERF_EN is defined.
module otter_hazard_unit
  import otter_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int LOAD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [ADDR_W-1:0] rs1_addr_d_i,
  input  logic [ADDR_W-1:0] rs2_addr_d_i,
  input  logic              rs1_used_d_i,
  input  logic              rs2_used_d_i,
  input  logic [ADDR_W-1:0] rd_e_i,
  input  logic [ADDR_W-1:0] rd_m_i,
  input  logic [ADDR_W-1:0] rd_w_i,
  input  logic              regwrite_e_i,
  input  logic              regwrite_m_i,
  input  logic              regwrite_w_i,
  input  logic              memread_e_i,
  input  logic              redirect_e_i,
  input  logic [XLEN-1:0]   wb_data_w_i,
  output logic              stall_f_o,
  output logic              stall_d_o,
  output logic              flush_d_o,
  output logic              flush_e_o,
  output logic [1:0]        fwd_a_e_o,
  output logic [1:0]        fwd_b_e_o,
  output logic [XLEN-1:0]   byp_data_e_o,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o
);

  localparam logic [1:0] CNT_INIT = (LOAD_LAT > 1) ? 2'(LOAD_LAT - 2) : 2'd0;

  logic [1:0]      sel_a;
  logic [1:0]      sel_b;
  logic            load_use_a;
  logic            load_use_b;
  logic            load_use;
  hz_state_t       state_q;
  logic [1:0]      cnt_q;
  logic            stall;
  logic            flush_d;
  logic            flush_e;
  logic [1:0]      fwd_a_d, fwd_a_q;
  logic [1:0]      fwd_b_d, fwd_b_q;
  logic [XLEN-1:0] byp_d, byp_q;

  otter_fwd_sel #(.ADDR_W(ADDR_W)) u_fwd_a (
    .rs_addr_i    (rs1_addr_d_i),
    .rs_used_i    (rs1_used_d_i),
    .rd_e_i       (rd_e_i),
    .rd_m_i       (rd_m_i),
    .rd_w_i       (rd_w_i),
    .regwrite_e_i (regwrite_e_i),
    .regwrite_m_i (regwrite_m_i),
    .regwrite_w_i (regwrite_w_i),
    .memread_e_i  (memread_e_i),
    .sel_o        (sel_a),
    .load_use_o   (load_use_a)
  );

  otter_fwd_sel #(.ADDR_W(ADDR_W)) u_fwd_b (
    .rs_addr_i    (rs2_addr_d_i),
    .rs_used_i    (rs2_used_d_i),
    .rd_e_i       (rd_e_i),
    .rd_m_i       (rd_m_i),
    .rd_w_i       (rd_w_i),
    .regwrite_e_i (regwrite_e_i),
    .regwrite_m_i (regwrite_m_i),
    .regwrite_w_i (regwrite_w_i),
    .memread_e_i  (memread_e_i),
    .sel_o        (sel_b),
    .load_use_o   (load_use_b)
  );

  assign load_use = load_use_a || load_use_b;

  // Redirect outranks any stall; the first stall cycle comes straight from the compare
  always_comb begin
    stall   = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (rst_n_i) begin
      if (redirect_e_i) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (state_q == LDSTALL || load_use) begin
        stall   = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  assign stall_f_o = stall;
  assign stall_d_o = stall;
  assign flush_d_o = flush_d;
  assign flush_e_o = flush_e;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else if (redirect_e_i) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_use && LOAD_LAT > 1) begin
            state_q <= LDSTALL;
            cnt_q   <= CNT_INIT;
          end
        end
        LDSTALL: begin
          if (cnt_q == 2'd0) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 2'd0;
        end
      endcase
    end
  end

  // A bubble entering E must select the register file and carry no bypass value
  always_comb begin
    fwd_a_d = flush_e ? FWD_RF : sel_a;
    fwd_b_d = flush_e ? FWD_RF : sel_b;
    byp_d   = byp_q;
    if (flush_e) begin
      byp_d = '0;
    end else if (sel_a == FWD_BYP || sel_b == FWD_BYP) begin
      byp_d = wb_data_w_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
      byp_q   <= '0;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      byp_q   <= byp_d;
    end
  end

  assign fwd_a_e_o    = fwd_a_q;
  assign fwd_b_e_o    = fwd_b_q;
  assign byp_data_e_o = byp_q;

`ifdef OTTER_HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (stall && stall_cnt_q != 32'hFFFF_FFFF) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (redirect_e_i && flush_cnt_q != 32'hFFFF_FFFF) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = 32'd0;
  assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_otter_hazard_unit.sv
// tb/tb_otter_hazard_unit.sv - randomized check of two hazard units (LOAD_LAT 1 and 3) against a rule model
module tb_otter_hazard_unit;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [AW-1:0] rs1_addr, rs2_addr, rd_e, rd_m, rd_w;
  logic          rs1_used, rs2_used, regwrite_e, regwrite_m, regwrite_w;
  logic          memread_e, redirect_e;
  logic [XLEN-1:0] wb_data;

  logic        stall_f [2];
  logic        stall_d [2];
  logic        flush_d [2];
  logic        flush_e [2];
  logic [1:0]  fwd_a   [2];
  logic [1:0]  fwd_b   [2];
  logic [31:0] byp     [2];
  logic [31:0] scnt    [2];
  logic [31:0] fcnt    [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    otter_hazard_unit #(.XLEN(XLEN), .NUM_REGS(32), .LOAD_LAT(g == 0 ? 1 : 3)) u_dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .rs1_addr_d_i (rs1_addr),
      .rs2_addr_d_i (rs2_addr),
      .rs1_used_d_i (rs1_used),
      .rs2_used_d_i (rs2_used),
      .rd_e_i       (rd_e),
      .rd_m_i       (rd_m),
      .rd_w_i       (rd_w),
      .regwrite_e_i (regwrite_e),
      .regwrite_m_i (regwrite_m),
      .regwrite_w_i (regwrite_w),
      .memread_e_i  (memread_e),
      .redirect_e_i (redirect_e),
      .wb_data_w_i  (wb_data),
      .stall_f_o    (stall_f[g]),
      .stall_d_o    (stall_d[g]),
      .flush_d_o    (flush_d[g]),
      .flush_e_o    (flush_e[g]),
      .fwd_a_e_o    (fwd_a[g]),
      .fwd_b_e_o    (fwd_b[g]),
      .byp_data_e_o (byp[g]),
      .stall_cnt_o  (scnt[g]),
      .flush_cnt_o  (fcnt[g])
    );
  end

  int checks   = 0;
  int failures = 0;

  // model state: remaining stall cycles, expected registered values, expected counters
  int          rem  [2];
  logic [1:0]  ea   [2];
  logic [1:0]  eb   [2];
  logic [31:0] ebyp [2];
  logic [31:0] esc  [2];
  logic [31:0] efc  [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [1:0] ref_sel(logic [AW-1:0] a, logic u);
    if (!u || a == 0) return 2'd0;
    if (regwrite_e && rd_e == a && !memread_e) return 2'd1;
    if (regwrite_m && rd_m == a) return 2'd2;
    if (regwrite_w && rd_w == a) return 2'd3;
    return 2'd0;
  endfunction

  function automatic bit ref_hazard();
    if (!memread_e || !regwrite_e || rd_e == 0) return 1'b0;
    return (rs1_used && rd_e == rs1_addr) || (rs2_used && rd_e == rs2_addr);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      rem[k] = 0; ea[k] = 0; eb[k] = 0; ebyp[k] = 0; esc[k] = 0; efc[k] = 0;
    end
  endtask

  task automatic check_regs();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("fwd_a[%0d]", k), 32'(fwd_a[k]), 32'(ea[k]));
      check($sformatf("fwd_b[%0d]", k), 32'(fwd_b[k]), 32'(eb[k]));
      check($sformatf("byp[%0d]", k), byp[k], ebyp[k]);
      check($sformatf("stall_cnt[%0d]", k), scnt[k], esc[k]);
      check($sformatf("flush_cnt[%0d]", k), fcnt[k], efc[k]);
    end
  endtask

  // checks combinational outputs, clocks once, then checks registered outputs
  task automatic cycle();
    bit st [2];
    bit fe [2];
    bit fd;
    bit hz;
    logic [1:0] sa, sb;
    #1;
    hz = ref_hazard();
    sa = ref_sel(rs1_addr, rs1_used);
    sb = ref_sel(rs2_addr, rs2_used);
    fd = rst_n && redirect_e;
    for (int k = 0; k < 2; k++) begin
      st[k] = rst_n && !redirect_e && (rem[k] > 0 || hz);
      fe[k] = rst_n && (redirect_e || st[k]);
      check($sformatf("stall_f[%0d]", k), 32'(stall_f[k]), 32'(st[k]));
      check($sformatf("stall_d[%0d]", k), 32'(stall_d[k]), 32'(st[k]));
      check($sformatf("flush_d[%0d]", k), 32'(flush_d[k]), 32'(fd));
      check($sformatf("flush_e[%0d]", k), 32'(flush_e[k]), 32'(fe[k]));
    end
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (fe[k]) begin
          ea[k] = 0; eb[k] = 0; ebyp[k] = 0;
        end else begin
          ea[k] = sa; eb[k] = sb;
          if (sa == 2'd3 || sb == 2'd3) ebyp[k] = wb_data;
        end
        if (redirect_e) rem[k] = 0;
        else if (rem[k] > 0) rem[k] = rem[k] - 1;
        else if (hz) rem[k] = lat_of(k) - 1;
`ifdef OTTER_HAZARD_PERF_EN
        if (st[k] && esc[k] != 32'hFFFF_FFFF) esc[k] = esc[k] + 1;
        if (redirect_e && efc[k] != 32'hFFFF_FFFF) efc[k] = efc[k] + 1;
`endif
      end
    end
    #1;
    check_regs();
  endtask

  task automatic clear_in();
    rs1_addr = 0; rs2_addr = 0; rs1_used = 1; rs2_used = 1;
    rd_e = 0; rd_m = 0; rd_w = 0;
    regwrite_e = 0; regwrite_m = 0; regwrite_w = 0;
    memread_e = 0; redirect_e = 0; wb_data = 0;
  endtask

  task automatic load_use(input logic [AW-1:0] r);
    clear_in();
    rs1_addr = r; rd_e = r; regwrite_e = 1; memread_e = 1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_in();
    model_clear();
    #1;
    check_regs();
    cycle();
    rst_n = 1'b1;

    // hazard-free: no source matches any stage
    clear_in();
    rs1_addr = 5; rd_e = 7; rd_m = 7; rd_w = 7;
    regwrite_e = 1; regwrite_m = 1; regwrite_w = 1;
    cycle();

    // load-use, then the load moves to M and the consumer forwards from WB
    load_use(3);
    cycle();
    clear_in();
    rs1_addr = 3; rd_m = 3; regwrite_m = 1;
    cycle(); cycle(); cycle();

    // long stall cut short by a redirect in its second cycle
    load_use(3);
    cycle();
    clear_in();
    redirect_e = 1;
    cycle();
    clear_in();
    cycle();

    // priority E over M over W, then E removed
    clear_in();
    rs2_addr = 4; rd_e = 4; rd_m = 4; rd_w = 4;
    regwrite_e = 1; regwrite_m = 1; regwrite_w = 1;
    cycle();
    rd_e = 0;
    cycle();

    // W bypass, then x0 never forwards
    clear_in();
    rs1_addr = 9; rd_w = 9; regwrite_w = 1; wb_data = 32'hDEADBEEF;
    cycle();
    rs1_addr = 0;
    cycle();

    // reset during an active multi-cycle stall, hazard inputs still asserted
    load_use(6);
    cycle();
    cycle();
    rst_n = 1'b0;
    #1;
    model_clear();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_stall[%0d]", k), 32'(stall_f[k]), 32'd0);
      check($sformatf("rst_flush_e[%0d]", k), 32'(flush_e[k]), 32'd0);
    end
    check_regs();
    cycle();
    rst_n = 1'b1;
    clear_in();
    cycle();

    // random traffic over a small register window to provoke matches
    for (int i = 0; i < 400; i++) begin
      rs1_addr   = AW'($urandom_range(0, 3));
      rs2_addr   = AW'($urandom_range(0, 3));
      rs1_used   = ($urandom_range(0, 9) < 8);
      rs2_used   = ($urandom_range(0, 9) < 8);
      rd_e       = AW'($urandom_range(0, 3));
      rd_m       = AW'($urandom_range(0, 3));
      rd_w       = AW'($urandom_range(0, 3));
      regwrite_e = 1'($urandom);
      regwrite_m = 1'($urandom);
      regwrite_w = 1'($urandom);
      memread_e  = ($urandom_range(0, 9) < 3);
      redirect_e = ($urandom_range(0, 9) < 1);
      wb_data    = $urandom;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
